// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Purpose : shared CPU-side constants and types. Holds the data-memory
//           geometry used by dmem_2p_responder, its FSM state type and a
//           small saturating-add helper for the out-of-range counter.
// Ports   : none (package).
// Config  : none here; see dmem_2p_responder for DMEM_RDW_BYPASS_EN.
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int MEM_ADDR_WIDTH = 32;
  localparam int MEM_DATA_WIDTH = 32;
  localparam int DMEM_DEPTH     = 1024;

  typedef enum logic {DMEM_INIT, DMEM_READY} dmem_state_t;

  // Source of the read-data output for the most recently accepted read.
  typedef enum logic [1:0] {
    RSEL_ZERO   = 2'd0,
    RSEL_ARRAY  = 2'd1,
    RSEL_BYPASS = 2'd2
  } dmem_rsel_t;

  // 16-bit add that clamps at 0xFFFF instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a,
                                            input logic [1:0]  inc);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// Purpose : plain 1-write/1-read synchronous word array with a registered
//           read port. Maps onto block RAM. Read-during-write to the same
//           index returns the previously stored word. No reset on contents.
// Ports   :
//   clk      in   clock
//   i_we     in   write enable
//   i_waddr  in   write index   [$clog2(DEPTH)-1:0]
//   i_wdata  in   write data    [DATA_WIDTH-1:0]
//   i_re     in   read enable (output register only updates when high)
//   i_raddr  in   read index    [$clog2(DEPTH)-1:0]
//   o_rdata  out  registered read data [DATA_WIDTH-1:0]
// ---------------------------------------------------------------------------
module dmem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0]    i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0]    o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_2p_responder.sv
// ---------------------------------------------------------------------------
// dmem_2p_responder
// Purpose : memory-side responder for the core's 2-port data-memory bus.
//           After every reset it clears the whole array (one word per
//           cycle, init_busy high), then services one write and one read
//           per cycle with a 1-cycle read latency. Out-of-range accesses
//           (any address bit above the index bits set) are dropped / read
//           as zero and are flagged (oor_err, sticky) and counted (oor_cnt,
//           saturating).
// Config  : `define DMEM_RDW_BYPASS_EN -> same-cycle read+write to the same
//           in-range index returns the new write data (write-first).
//           Undefined (default) -> returns the old stored word (read-first).
// Ports   :
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   dmem_waddr   in   write word address   [ADDR_WIDTH-1:0]
//   dmem_wdata   in   write data           [DATA_WIDTH-1:0]
//   dmem_wen     in   write enable
//   dmem_raddr   in   read word address    [ADDR_WIDTH-1:0]
//   dmem_ren     in   read enable
//   dmem_rdata   out  read data, valid with dmem_rvalid [DATA_WIDTH-1:0]
//   dmem_rvalid  out  read response strobe (1 cycle after dmem_ren)
//   init_busy    out  high while the clear sequence runs
//   oor_err      out  sticky out-of-range flag
//   oor_cnt      out  saturating out-of-range access count [15:0]
// ---------------------------------------------------------------------------
module dmem_2p_responder
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int DEPTH      = DMEM_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] dmem_waddr,
  input  logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_wen,
  input  logic [ADDR_WIDTH-1:0] dmem_raddr,
  input  logic                  dmem_ren,
  output logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  dmem_rvalid,
  output logic                  init_busy,
  output logic                  oor_err,
  output logic [15:0]           oor_cnt
);

  localparam int IDX_W = $clog2(DEPTH);

  dmem_state_t      r_state;
  logic [IDX_W-1:0] r_ptr;
  logic             r_init_busy;
  logic             r_rvalid;
  dmem_rsel_t       r_rsel;
  logic             r_oor_err;
  logic [15:0]      r_oor_cnt;

  logic [IDX_W-1:0]      w_widx;
  logic [IDX_W-1:0]      w_ridx;
  logic                  w_waddr_oor;
  logic                  w_raddr_oor;
  logic                  w_ready;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic [1:0]            w_oor_inc;
  dmem_rsel_t            w_rd_sel;
  logic                  w_arr_we;
  logic [IDX_W-1:0]      w_arr_waddr;
  logic [DATA_WIDTH-1:0] w_arr_wdata;
  logic                  w_arr_re;
  logic [DATA_WIDTH-1:0] w_arr_rdata;

  // ---------------- address decode ----------------
  assign w_widx = dmem_waddr[IDX_W-1:0];
  assign w_ridx = dmem_raddr[IDX_W-1:0];

  // When the address is exactly as wide as the index there are no upper
  // bits, so nothing can be out of range.
  generate
    if (ADDR_WIDTH > IDX_W) begin : g_oor_decode
      assign w_waddr_oor = |dmem_waddr[ADDR_WIDTH-1:IDX_W];
      assign w_raddr_oor = |dmem_raddr[ADDR_WIDTH-1:IDX_W];
    end else begin : g_no_oor_decode
      assign w_waddr_oor = 1'b0;
      assign w_raddr_oor = 1'b0;
    end
  endgenerate

  // Requests only count once the clear has finished and reset is low.
  assign w_ready   = (r_state == DMEM_READY) && !rst;
  assign w_wr_acc  = w_ready && dmem_wen;
  assign w_rd_acc  = w_ready && dmem_ren;
  assign w_wr_ok   = w_wr_acc && !w_waddr_oor;
  assign w_rd_ok   = w_rd_acc && !w_raddr_oor;
  assign w_oor_inc = {1'b0, (w_wr_acc && w_waddr_oor)}
                   + {1'b0, (w_rd_acc && w_raddr_oor)};

  // ---------------- array write-port mux ----------------
  // During INIT the clear pointer owns the write port; bus writes are ignored.
  assign w_arr_we    = !rst && ((r_state == DMEM_INIT) || w_wr_ok);
  assign w_arr_waddr = (r_state == DMEM_INIT) ? r_ptr : w_widx;
  assign w_arr_wdata = (r_state == DMEM_INIT) ? '0 : dmem_wdata;
  assign w_arr_re    = w_rd_ok;

  dmem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk     (clk),
    .i_we    (w_arr_we),
    .i_waddr (w_arr_waddr),
    .i_wdata (w_arr_wdata),
    .i_re    (w_arr_re),
    .i_raddr (w_ridx),
    .o_rdata (w_arr_rdata)
  );

  // ---------------- init FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= DMEM_INIT;
      r_ptr       <= '0;
      r_init_busy <= 1'b1;
    end else begin
      case (r_state)
        DMEM_INIT: begin
          r_ptr <= r_ptr + 1'b1;
          // DEPTH is a power of two, so the last index is all ones.
          if (&r_ptr) begin
            r_state     <= DMEM_READY;
            r_init_busy <= 1'b0;
          end
        end
        DMEM_READY: begin
          r_state <= DMEM_READY;
        end
        default: begin
          r_state <= DMEM_INIT;
        end
      endcase
    end
  end

  // ---------------- read-source selection ----------------
`ifdef DMEM_RDW_BYPASS_EN
  logic                  w_rdw_hit;
  logic [DATA_WIDTH-1:0] r_byp_data;

  assign w_rdw_hit = w_wr_ok && w_rd_ok && (w_widx == w_ridx);

  always_comb begin
    w_rd_sel = RSEL_ARRAY;
    if (w_raddr_oor) begin
      w_rd_sel = RSEL_ZERO;
    end else if (w_rdw_hit) begin
      w_rd_sel = RSEL_BYPASS;
    end
  end

  // Captures the write data on a read/write collision; held until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byp_data <= '0;
    end else if (w_rdw_hit) begin
      r_byp_data <= dmem_wdata;
    end
  end
`else
  // The array is read-first, so a collision naturally returns the old word.
  always_comb begin
    w_rd_sel = RSEL_ARRAY;
    if (w_raddr_oor) begin
      w_rd_sel = RSEL_ZERO;
    end
  end
`endif

  // ---------------- response and OOR registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rvalid  <= 1'b0;
      r_rsel    <= RSEL_ZERO;
      r_oor_err <= 1'b0;
      r_oor_cnt <= '0;
    end else begin
      r_rvalid <= w_rd_acc;
      // Selection only moves on an accepted read, so rdata holds otherwise.
      if (w_rd_acc) begin
        r_rsel <= w_rd_sel;
      end
      if (w_oor_inc != 2'd0) begin
        r_oor_err <= 1'b1;
        r_oor_cnt <= sat_add16(r_oor_cnt, w_oor_inc);
      end
    end
  end

  // Output mux is driven purely by registers, keeping rdata a clean
  // 1-cycle response.
  always_comb begin
    dmem_rdata = '0;
    case (r_rsel)
      RSEL_ARRAY:  dmem_rdata = w_arr_rdata;
`ifdef DMEM_RDW_BYPASS_EN
      RSEL_BYPASS: dmem_rdata = r_byp_data;
`endif
      default:     dmem_rdata = '0;
    endcase
  end

  assign dmem_rvalid = r_rvalid;
  assign init_busy   = r_init_busy;
  assign oor_err     = r_oor_err;
  assign oor_cnt     = r_oor_cnt;

endmodule

// File: doc/dmem_2p_responder.md
# dmem_2p_responder

Memory-side responder for the CPU's true 2-port data-memory interface: services the MA stage's write port (waddr/wdata/wen) and read port (raddr/ren → rdata) against an internal word array. After every reset it runs a self-clearing init sequence that zeroes the array before accepting traffic. It sits outside the CPU core, wired directly to the core's dmem_* ports. It also flags and counts out-of-range accesses for bring-up debug.

## Interface
- ADDR_WIDTH, default MEM_ADDR_WIDTH: width of both address ports (word addresses).
- DATA_WIDTH, default MEM_DATA_WIDTH: word width.
- DEPTH, default DMEM_DEPTH (1024): number of words; power of two, ≥ 2. IDX_W = $clog2(DEPTH).
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- dmem_waddr  input  ADDR_WIDTH  write word address.
- dmem_wdata  input  DATA_WIDTH  write data.
- dmem_wen  input  1  write enable, one word per cycle.
- dmem_raddr  input  ADDR_WIDTH  read word address.
- dmem_ren  input  1  read enable.
- dmem_rdata  output  DATA_WIDTH  read data; valid when dmem_rvalid is high.
- dmem_rvalid  output  1  read response strobe.
- init_busy  output  1  high while the clear sequence runs.
- oor_err  output  1  sticky: at least one out-of-range access since reset.
- oor_cnt  output  16  saturating count of out-of-range accesses.

## Operation
- Reset values: dmem_rdata=0, dmem_rvalid=0, init_busy=1, oor_err=0, oor_cnt=0, state=INIT, clear pointer=0.
- FSM states: INIT, READY.
  - INIT: writes 0 to mem[ptr] and increments ptr each cycle. When ptr==DEPTH-1, that word is written, then state moves to READY and init_busy drops.
  - READY: terminal until reset.
- Requests seen in INIT are ignored: no write, no rvalid, no OOR accounting.
- Address decode: idx = addr[IDX_W-1:0]. An address is out of range if any addr[ADDR_WIDTH-1:IDX_W] bit is set.
- Write (READY, wen=1): if in range, mem[idx] <= wdata. If out of range, the write is dropped.
- Read (READY, ren=1): one cycle later dmem_rvalid=1 and dmem_rdata=mem[idx]. Out-of-range reads return 0 with rvalid=1.
- ren=0: the next-cycle dmem_rvalid=0 and dmem_rdata holds its previous value.
- Simultaneous read and write to different indices: both are serviced independently.
- Simultaneous read and write to the same in-range index: behaviour is set by the macro (see Configuration).
- OOR accounting: oor_cnt increments by the number of offending ports that cycle (0, 1 or 2) and saturates at 0xFFFF. oor_err sets on the first offence and clears only on rst.
- rst asserted mid-INIT or mid-traffic: next cycle all outputs return to reset values and the clear restarts from ptr=0. A pending read response is discarded.

## Timing
- Read latency is exactly 1 cycle (registered rdata). Throughput is 1 read plus 1 write per cycle.
- Write is visible to a read issued in the following cycle or later.
- Init duration: rst deasserted at edge N; init_busy falls after edge N+DEPTH. The first accepted request is at edge N+DEPTH+1.
- No back-pressure; requests have no ready signal.

## Configuration
- DMEM_RDW_BYPASS_EN defined: a same-cycle read and write to the same in-range index returns the new wdata (write-first).
- DMEM_RDW_BYPASS_EN undefined: the same case returns the old stored word (read-first). The write still lands.

## Structure
- cpu_pkg holds:
  - DMEM_DEPTH (MEM_ADDR_WIDTH and MEM_DATA_WIDTH already live there).
  - typedef enum logic {DMEM_INIT, DMEM_READY} dmem_state_t.
- One sub-module, dmem_array: a plain 1W1R synchronous word array with registered read. It holds no bypass or init logic.
- The top holds the FSM, clear-write muxing onto the array write port, OOR decode/counters and the bypass mux.

## Test plan
- Reset then idle: init_busy high for exactly DEPTH cycles after rst release. Reading idx 0, DEPTH/2 and DEPTH-1 afterwards returns 0 with rvalid one cycle after each ren.
- Write 0xDEADBEEF to addr 5, read addr 5 next cycle → rdata=0xDEADBEEF, rvalid=1 one cycle later.
- Store 0x11111111 at addr 7, then same-cycle write 0x22222222 and read of addr 7 → 0x22222222 with the macro, 0x11111111 without. A later read returns 0x22222222 in both builds.
- Write addr DEPTH with 0xABCD and, in the same cycle, read addr DEPTH+1 → oor_cnt=2, oor_err=1, rdata=0. mem[0] and mem[1] are unchanged.
- Force 0xFFFF out-of-range accesses and then one more → oor_cnt stays at 0xFFFF.
- Assert rst for one cycle at init ptr=300 → init_busy stays high a further DEPTH cycles. Words written before the reset read back 0.
